angle_bank_scheduler: RTL and testbench
=======================================

ANGLE_BANK_SCHEDULER -- requirements
Module: angle_bank_scheduler

Interface
REQ-001 SHALL have parameter NUM_ANGLES, default 180, angles per frame (>=2).
REQ-002 SHALL have parameter ANGLE_WIDTH, default 9, width of angle indices.
REQ-003 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-005 SHALL have port kick  in  1  start-of-frame pulse.
REQ-006 SHALL have port fl_start  out  1  one-cycle pulse: filter fills bank fl_bank with angle fl_angle.
REQ-007 SHALL have port fl_bank  out  1  bank index being filled.
REQ-008 SHALL have port fl_angle  out  ANGLE_WIDTH  angle being filled.
REQ-009 SHALL have port fl_done  in  1  pulse: current fill complete.
REQ-010 SHALL have port pr_angle  out  ANGLE_WIDTH  angle held in the processing bank.
REQ-011 SHALL have port pr_bank  out  1  bank currently IN_USE by processing.
REQ-012 SHALL have port pr_has_next_angle  out  1  further angles remain in frame.
REQ-013 SHALL have ports pr_next_angle (in), pr_next_angle_ack (out), 1 bit each: advance-angle handshake.
REQ-014 SHALL have ports pr_prev_angle_release (in), pr_prev_angle_release_ack (out), 1 bit each: bank-release handshake.
REQ-015 SHALL have ports busy (out, 1, frame active), done (out, 1, end-of-frame pulse), db_stall_cnt (out, 16, stall counter).

Function
REQ-016 SHALL hold per-bank state FREE, FILLING, FULL, IN_USE, RELEASING, and a frame FSM IDLE -> RUN -> IDLE; busy = (RUN).
REQ-017 SHALL, on kick in IDLE, clear fill counter, fill pointer, pr_angle, rd_bank and rd_valid, and enter RUN; kick in RUN SHALL be ignored.
REQ-018 SHALL register fl_start for one cycle when RUN, bank[fill pointer]==FREE, no bank FILLING, fill counter < NUM_ANGLES; same edge: bank -> FILLING, fl_bank/fl_angle latched, pointer toggles.
REQ-019 SHALL, on fl_done, move the FILLING bank to FULL and increment fill counter; fl_done with no bank FILLING SHALL be ignored.
REQ-020 SHALL assert pr_next_angle_ack combinationally iff pr_next_angle && rd_valid && bank[!rd_bank]==FULL && no bank RELEASING; on ack edge: old bank -> RELEASING, new bank -> IN_USE, rd_bank toggles, pr_angle increments.
REQ-021 SHALL assert pr_prev_angle_release_ack combinationally iff pr_prev_angle_release and one of: (a) a bank RELEASING -> that bank FREE; (b) !rd_valid and bank[rd_bank]==FULL -> bank IN_USE, rd_valid=1 (first angle); (c) rd_valid, !pr_has_next_angle, none RELEASING -> IN_USE bank FREE, rd_valid=0, done pulse, FSM -> IDLE; otherwise ack SHALL stay 0.
REQ-022 SHALL drive pr_has_next_angle = RUN && (!rd_valid || pr_angle != NUM_ANGLES-1).
REQ-023 SHALL evaluate all ack/fill conditions on registered bank state: a bank reaching FULL or FREE is usable one cycle later.
REQ-024 SHALL allow next-angle ack and release ack (case a) in the same cycle; both updates apply.
REQ-025 SHALL never hold both banks FILLING, nor two banks IN_USE.

Reset
REQ-026 SHALL, with reset_n low at a clock edge (including mid-frame), go IDLE, set both banks FREE, all counters/pointers/rd_valid 0, and all outputs 0; in-flight fills SHALL be discarded.

Configuration
REQ-027 SHALL, with NABP_SCHED_STATS_EN defined, count cycles where pr_next_angle && !pr_next_angle_ack in RUN on db_stall_cnt, saturating at 0xFFFF, cleared on kick and reset.
REQ-028 SHALL, without NABP_SCHED_STATS_EN, tie db_stall_cnt to 0 and omit the counter logic.

Verification
REQ-029 NUM_ANGLES=4, kick, fl_done 3 cycles after each fl_start, processing requests eagerly -> fl_angle 0,1,2,3 on banks 0,1,0,1; pr_angle 0..3; done pulses once; busy falls same edge.
REQ-030 Release asserted before first fill completes -> ack stays 0 until bank0 FULL, then ack, pr_bank=0, pr_angle=0.
REQ-031 pr_next_angle held while bank1 FILLING for 10 cycles, STATS_EN defined -> ack one cycle after bank1 FULL; db_stall_cnt=11.
REQ-032 Next-angle ack and case-(a) release in same cycle -> old RELEASING bank FREE, new IN_USE, no fl_start until following cycle.
REQ-033 reset_n low mid-frame with bank FILLING, then kick -> subsequent fl_start has fl_angle=0, fl_bank=0; late fl_done before kick ignored.
REQ-034 kick while busy, and fl_done with no bank FILLING -> no state change, no fl_start.

Source files
------------

// File: rtl/angle_bank_scheduler.sv
// Ping-pong bank scheduler: sequences filter fills and processing handshakes across one frame of angles.
// Define NABP_SCHED_STATS_EN to build the db_stall_cnt next-angle stall counter.
module angle_bank_scheduler #(
  parameter int NUM_ANGLES  = 180,
  parameter int ANGLE_WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   kick,
  output logic                   fl_start,
  output logic                   fl_bank,
  output logic [ANGLE_WIDTH-1:0] fl_angle,
  input  logic                   fl_done,
  output logic [ANGLE_WIDTH-1:0] pr_angle,
  output logic                   pr_bank,
  output logic                   pr_has_next_angle,
  input  logic                   pr_next_angle,
  output logic                   pr_next_angle_ack,
  input  logic                   pr_prev_angle_release,
  output logic                   pr_prev_angle_release_ack,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            db_stall_cnt
);
  localparam int CW = ANGLE_WIDTH + 1;
  localparam logic [CW-1:0]          FILL_TOTAL = CW'(NUM_ANGLES);
  localparam logic [ANGLE_WIDTH-1:0] LAST_ANGLE = ANGLE_WIDTH'(NUM_ANGLES - 1);

  typedef enum logic [2:0] {FREE, FILLING, FULL, IN_USE, RELEASING} bank_t;
  typedef enum logic {IDLE, RUN} frame_t;

  frame_t        state;
  bank_t         bank_st [2];
  logic [CW-1:0] fill_cnt;
  logic          fill_ptr;
  logic          rd_bank;
  logic          rd_valid;

  logic run, any_filling, any_releasing, fill_idx, rel_idx;
  logic fill_go, rel_a, rel_b, rel_c;

  // Every decision looks only at registered bank state, so a bank freed or
  // filled on one edge becomes usable on the next.
  always_comb begin
    run               = (state == RUN);
    any_filling       = (bank_st[0] == FILLING) || (bank_st[1] == FILLING);
    fill_idx          = (bank_st[1] == FILLING);
    any_releasing     = (bank_st[0] == RELEASING) || (bank_st[1] == RELEASING);
    rel_idx           = (bank_st[1] == RELEASING);
    pr_has_next_angle = run && (!rd_valid || (pr_angle != LAST_ANGLE));
    pr_next_angle_ack = pr_next_angle && rd_valid && (bank_st[~rd_bank] == FULL) && !any_releasing;
    rel_a             = pr_prev_angle_release && any_releasing;
    rel_b             = pr_prev_angle_release && run && !rd_valid && (bank_st[rd_bank] == FULL);
    rel_c             = pr_prev_angle_release && rd_valid && !pr_has_next_angle && !any_releasing;
    pr_prev_angle_release_ack = rel_a || rel_b || rel_c;
    fill_go           = run && (bank_st[fill_ptr] == FREE) && !any_filling && (fill_cnt < FILL_TOTAL);
  end

  assign busy    = (state == RUN);
  assign pr_bank = rd_bank;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      bank_st[0] <= FREE;
      bank_st[1] <= FREE;
      fill_cnt   <= '0;
      fill_ptr   <= 1'b0;
      rd_bank    <= 1'b0;
      rd_valid   <= 1'b0;
      pr_angle   <= '0;
      fl_start   <= 1'b0;
      fl_bank    <= 1'b0;
      fl_angle   <= '0;
      done       <= 1'b0;
    end else begin
      fl_start <= 1'b0;
      done     <= 1'b0;
      if (state == IDLE) begin
        if (kick) begin
          state    <= RUN;
          fill_cnt <= '0;
          fill_ptr <= 1'b0;
          pr_angle <= '0;
          rd_bank  <= 1'b0;
          rd_valid <= 1'b0;
        end
      end else begin
        if (fill_go) begin
          fl_start          <= 1'b1;
          fl_bank           <= fill_ptr;
          fl_angle          <= fill_cnt[ANGLE_WIDTH-1:0];
          bank_st[fill_ptr] <= FILLING;
          fill_ptr          <= ~fill_ptr;
        end
        if (fl_done && any_filling) begin
          bank_st[fill_idx] <= FULL;
          fill_cnt          <= fill_cnt + CW'(1);
        end
        // The banks touched below are never the FREE/FILLING ones above.
        if (pr_next_angle_ack) begin
          bank_st[rd_bank]  <= RELEASING;
          bank_st[~rd_bank] <= IN_USE;
          rd_bank           <= ~rd_bank;
          pr_angle          <= pr_angle + ANGLE_WIDTH'(1);
        end
        if (rel_a) begin
          bank_st[rel_idx] <= FREE;
        end else if (rel_b) begin
          bank_st[rd_bank] <= IN_USE;
          rd_valid         <= 1'b1;
        end else if (rel_c) begin
          bank_st[rd_bank] <= FREE;
          rd_valid         <= 1'b0;
          done             <= 1'b1;
          state            <= IDLE;
        end
      end
    end
  end

`ifdef NABP_SCHED_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if ((state == IDLE) && kick) begin
      stall_q <= '0;
    end else if (run && pr_next_angle && !pr_next_angle_ack && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign db_stall_cnt = stall_q;
`else
  assign db_stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_angle_bank_scheduler.sv
// Scoreboarded bench for angle_bank_scheduler with a 4-angle frame: directed fill/processing scenarios.
module tb_angle_bank_scheduler;
  localparam int NA = 4;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          reset_n, kick, fl_done_auto, fl_done_man;
  logic          pr_next_angle, pr_prev_angle_release;
  logic          fl_start, fl_bank, pr_bank, pr_has_next_angle;
  logic          pr_next_angle_ack, pr_prev_angle_release_ack, busy, done;
  logic [AW-1:0] fl_angle, pr_angle;
  logic [15:0]   db_stall_cnt;

  int  checks = 0;
  int  errors = 0;
  int  done_cnt = 0;
  bit  auto_fill = 1'b0;
  bit  pend_next = 1'b0;
  bit  pend_rel = 1'b0;
  logic [AW:0] fill_q[$];
  logic [AW:0] next_q[$];
  logic [AW:0] rel_q[$];
  logic [15:0] exp_stall;

  always #5 clk = ~clk;

  angle_bank_scheduler #(.NUM_ANGLES(NA), .ANGLE_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .kick(kick),
    .fl_start(fl_start), .fl_bank(fl_bank), .fl_angle(fl_angle),
    .fl_done(fl_done_auto | fl_done_man),
    .pr_angle(pr_angle), .pr_bank(pr_bank), .pr_has_next_angle(pr_has_next_angle),
    .pr_next_angle(pr_next_angle), .pr_next_angle_ack(pr_next_angle_ack),
    .pr_prev_angle_release(pr_prev_angle_release),
    .pr_prev_angle_release_ack(pr_prev_angle_release_ack),
    .busy(busy), .done(done), .db_stall_cnt(db_stall_cnt)
  );

  function automatic logic [AW:0] ba(input int b, input int a);
    logic [AW:0] r;
    r = {b[0], a[AW-1:0]};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick_pulse();
    kick = 1'b1;
    tick();
    kick = 1'b0;
  endtask

  task automatic pulse_done();
    fl_done_man = 1'b1;
    tick();
    fl_done_man = 1'b0;
  endtask

  task automatic wait_ack(input bit rel, input string name);
    int n = 0;
    bit got = 1'b0;
    while (!got && n < 100) begin
      @(negedge clk);
      got = rel ? pr_prev_angle_release_ack : pr_next_angle_ack;
      n++;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: no ack after %0d cycles, required within 100", name, n);
    end
    tick();
  endtask

  task automatic do_release(input logic [AW:0] exp);
    rel_q.push_back(exp);
    pr_prev_angle_release = 1'b1;
    wait_ack(1'b1, "release_ack_wait");
    pr_prev_angle_release = 1'b0;
  endtask

  task automatic do_next(input logic [AW:0] exp);
    next_q.push_back(exp);
    pr_next_angle = 1'b1;
    wait_ack(1'b0, "next_ack_wait");
    pr_next_angle = 1'b0;
  endtask

  // Filter model: completes each fill three cycles after its start pulse.
  initial begin
    fl_done_auto = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_fill && fl_start) begin
        repeat (3) @(posedge clk);
        #1 fl_done_auto = 1'b1;
        @(posedge clk);
        #1 fl_done_auto = 1'b0;
      end
    end
  end

  // Monitor: each fill start and each accepted handshake pops one expectation.
  always @(negedge clk) begin : monitor
    logic [AW:0] e;
    if (pend_next) begin
      if (next_q.size() == 0) check("unexpected_next_ack", 32'(pend_next), 0);
      else begin e = next_q.pop_front(); check("next_ack_bank_angle", 32'({pr_bank, pr_angle}), 32'(e)); end
    end
    if (pend_rel) begin
      if (rel_q.size() == 0) check("unexpected_release_ack", 32'(pend_rel), 0);
      else begin e = rel_q.pop_front(); check("release_ack_bank_angle", 32'({pr_bank, pr_angle}), 32'(e)); end
    end
    pend_next = pr_next_angle_ack;
    pend_rel  = pr_prev_angle_release_ack;
    if (fl_start === 1'b1) begin
      if (fill_q.size() == 0) check("unexpected_fl_start", 32'(fl_start), 0);
      else begin e = fill_q.pop_front(); check("fill_bank_angle", 32'({fl_bank, fl_angle}), 32'(e)); end
    end
    if (done === 1'b1) begin
      done_cnt++;
      check("busy_low_with_done", 32'(busy), 0);
    end
  end

  initial begin
`ifdef NABP_SCHED_STATS_EN
    exp_stall = 16'd11;
`else
    exp_stall = 16'd0;
`endif
    reset_n = 1'b0; kick = 1'b0; fl_done_man = 1'b0;
    pr_next_angle = 1'b0; pr_prev_angle_release = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    check("rst_busy", 32'(busy), 0);
    check("rst_outputs", 32'({fl_start, fl_bank, fl_angle, pr_bank, pr_angle, pr_has_next_angle, done}), 0);
    check("rst_acks", 32'({pr_next_angle_ack, pr_prev_angle_release_ack}), 0);
    check("rst_stall", 32'(db_stall_cnt), 0);

    // Full frame, automatic fills, eager processing
    for (int a = 0; a < NA; a++) fill_q.push_back(ba(a % 2, a));
    auto_fill = 1'b1;
    kick_pulse();
    check("busy_after_kick", 32'(busy), 1);
    check("has_next_at_start", 32'(pr_has_next_angle), 1);
    do_release(ba(0, 0));
    for (int a = 0; a < NA - 1; a++) begin
      check("has_next_mid_frame", 32'(pr_has_next_angle), 1);
      do_next(ba((a + 1) % 2, a + 1));
      do_release(ba((a + 1) % 2, a + 1));
    end
    check("has_next_last_angle", 32'(pr_has_next_angle), 0);
    do_release(ba(1, NA - 1));
    repeat (3) tick();
    check("done_count_frame", 32'(done_cnt), 1);
    check("busy_after_frame", 32'(busy), 0);
    auto_fill = 1'b0;

    // Release before first fill completes; next-angle stalled on a filling bank
    fill_q.push_back(ba(0, 0));
    fill_q.push_back(ba(1, 1));
    kick_pulse();
    pr_prev_angle_release = 1'b1;
    rel_q.push_back(ba(0, 0));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("release_ack_before_full", 32'(pr_prev_angle_release_ack), 0);
    end
    tick();
    pulse_done();
    wait_ack(1'b1, "first_release_wait");
    pr_prev_angle_release = 1'b0;
    pr_next_angle = 1'b1;
    next_q.push_back(ba(1, 1));
    repeat (10) @(posedge clk);
    #1 fl_done_man = 1'b1;
    @(negedge clk);
    check("next_ack_while_filling", 32'(pr_next_angle_ack), 0);
    @(posedge clk);
    #1 fl_done_man = 1'b0;
    @(negedge clk);
    check("next_ack_after_full", 32'(pr_next_angle_ack), 1);
    check("db_stall_cnt", 32'(db_stall_cnt), 32'(exp_stall));
    tick();
    pr_next_angle = 1'b0;

    // Freed bank refills only on the following cycle
    fill_q.push_back(ba(0, 2));
    do_release(ba(1, 1));
    @(negedge clk);
    check("no_fill_same_cycle_as_free", 32'(fl_start), 0);
    @(negedge clk);
    check("fill_cycle_after_free", 32'(fl_start), 1);
    tick();

    // Mid-frame reset while bank0 is filling
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_pr", 32'({pr_bank, pr_angle, pr_has_next_angle}), 0);
    check("midrst_fill", 32'({fl_start, fl_bank, fl_angle}), 0);
    check("midrst_stall", 32'(db_stall_cnt), 0);
    pulse_done();
    repeat (2) tick();
    fill_q.push_back(ba(0, 0));
    kick_pulse();

    // Stray fl_done and kick while both banks are full are ignored
    fill_q.push_back(ba(1, 1));
    repeat (3) tick();
    pulse_done();
    repeat (3) tick();
    pulse_done();
    repeat (2) tick();
    pulse_done();
    kick_pulse();
    check("busy_after_ignored_kick", 32'(busy), 1);
    check("pr_state_after_ignored", 32'({pr_angle, pr_has_next_angle}), 1);
    repeat (4) tick();
    do_release(ba(0, 0));
    do_next(ba(1, 1));
    fill_q.push_back(ba(0, 2));
    do_release(ba(1, 1));
    repeat (4) tick();

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (2) tick();
    check("fill_q_drained", 32'(fill_q.size()), 0);
    check("next_q_drained", 32'(next_q.size()), 0);
    check("rel_q_drained", 32'(rel_q.size()), 0);
    check("done_count_total", 32'(done_cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
